// File: rtl/idwt_synthesis_pkg.sv
// Shared constants, types and Daubechies-10 reconstruction filters (1.14 fixed point)
// for the inverse wavelet synthesis stage.
package idwt_synthesis_pkg;

  localparam int DATA_W       = 32;
  localparam int COEF_W       = 32;
  localparam int ACC_W        = 64;
  localparam int TAPS         = 20;
  localparam int HALF         = TAPS / 2;
  localparam int FXP_BITS_DEF = 14;

  typedef logic signed [DATA_W-1:0] samp_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam acc_t SAT_HI = 64'sd2147483647;
  localparam acc_t SAT_LO = -64'sd2147483648;

  typedef struct packed {
    logic vld;
    logic phase;
  } tag_t;

  // rec_lo is the time reverse of dec_lo; rec_hi[k] = (-1)^k * dec_lo[k]
  localparam coef_t LO_R [TAPS] = '{
    32'sd437,   32'sd3083,  32'sd8638,  32'sd11280, 32'sd4607,
    -32'sd4093, -32'sd3210, 32'sd2087,  32'sd1525,  -32'sd1170,
    -32'sd483,  32'sd544,   32'sd59,    -32'sd176,  32'sd23,
    32'sd33,    -32'sd11,   -32'sd2,    32'sd2,     32'sd0
  };

  localparam coef_t HI_R [TAPS] = '{
    32'sd0,     -32'sd2,    -32'sd2,    32'sd11,    32'sd33,
    -32'sd23,   -32'sd176,  -32'sd59,   32'sd544,   32'sd483,
    -32'sd1170, -32'sd1525, 32'sd2087,  32'sd3210,  -32'sd4093,
    -32'sd4607, 32'sd11280, -32'sd8638, 32'sd3083,  -32'sd437
  };

endpackage

// File: rtl/idwt_synthesis_sat_shift.sv
// Arithmetic right shift of a 64-bit accumulator by SHIFT fractional bits,
// then saturation to the signed 32-bit range.
module idwt_synthesis_sat_shift
  import idwt_synthesis_pkg::*;
#(
  parameter int SHIFT = FXP_BITS_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] sat_o
);

  function automatic samp_t shift_sat(input acc_t acc);
    acc_t sh;
    sh = acc >>> SHIFT;
    if (sh > SAT_HI) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sh < SAT_LO) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return sh[DATA_W-1:0];
    end
  endfunction

  always_comb begin
    sat_o = shift_sat(acc_i);
  end

endmodule

// File: rtl/idwt_synthesis.sv
// Polyphase Daubechies-10 synthesis: one (cA, cD) pair in, even then odd
// reconstructed sample out through a 5-stage registered adder tree.
module idwt_synthesis
  import idwt_synthesis_pkg::*;
#(
  parameter int FXP_BITS = FXP_BITS_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_approx,
  input  logic signed [DATA_W-1:0] in_detail,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_phase
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVEN = 2'd1;
  localparam logic [1:0] S_ODD  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       accept, odd_sel;

  samp_t abuf_q [HALF];
  samp_t abuf_d [HALF];
  samp_t dbuf_q [HALF];
  samp_t dbuf_d [HALF];

  acc_t prod_p0_q [TAPS];
  acc_t prod_p0_d [TAPS];
  acc_t sum_p1_q [HALF];
  acc_t sum_p1_d [HALF];
  acc_t sum_p2_q [HALF/2];
  acc_t sum_p2_d [HALF/2];
  acc_t sum_p3_q [2];
  acc_t sum_p3_d [2];
  acc_t sum_p4_q, sum_p4_d;
  tag_t tag_p0_q, tag_p0_d, tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d;
  tag_t tag_p3_q, tag_p3_d, tag_p4_q, tag_p4_d;

  samp_t sat_val;
  logic  out_valid_q, out_valid_d;
  samp_t out_data_q, out_data_d;
  logic  out_phase_q, out_phase_d;

  idwt_synthesis_sat_shift #(.SHIFT(FXP_BITS)) u_sat_shift (
    .acc_i (sum_p4_q),
    .sat_o (sat_val)
  );

  always_comb begin
    accept  = in_valid && in_ready_q;
    odd_sel = (state_q == S_ODD);

    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_EVEN : S_IDLE;
      S_EVEN:  state_d = S_ODD;
      S_ODD:   state_d = accept ? S_EVEN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d != S_EVEN);

    abuf_d = abuf_q;
    dbuf_d = dbuf_q;
    if (accept) begin
      abuf_d[0] = in_approx;
      dbuf_d[0] = in_detail;
      for (int k = 1; k < HALF; k++) begin
        abuf_d[k] = abuf_q[k-1];
        dbuf_d[k] = dbuf_q[k-1];
      end
    end

    // Stage p0: products read the pre-shift buffers, so S_ODD can accept safely
    tag_p0_d.vld   = (state_q == S_EVEN) || odd_sel;
    tag_p0_d.phase = odd_sel;
    for (int k = 0; k < HALF; k++) begin
      prod_p0_d[2*k]   = ACC_W'(odd_sel ? LO_R[2*k+1] : LO_R[2*k]) * ACC_W'(abuf_q[k]);
      prod_p0_d[2*k+1] = ACC_W'(odd_sel ? HI_R[2*k+1] : HI_R[2*k]) * ACC_W'(dbuf_q[k]);
    end

    // Stage p1: 20 -> 10
    tag_p1_d = tag_p0_q;
    for (int i = 0; i < HALF; i++) begin
      sum_p1_d[i] = prod_p0_q[2*i] + prod_p0_q[2*i+1];
    end

    // Stage p2: 10 -> 5
    tag_p2_d = tag_p1_q;
    for (int i = 0; i < HALF/2; i++) begin
      sum_p2_d[i] = sum_p1_q[2*i] + sum_p1_q[2*i+1];
    end

    // Stage p3: 5 -> 2
    tag_p3_d    = tag_p2_q;
    sum_p3_d[0] = sum_p2_q[0] + sum_p2_q[1];
    sum_p3_d[1] = sum_p2_q[2] + sum_p2_q[3] + sum_p2_q[4];

    // Stage p4: 2 -> 1
    tag_p4_d = tag_p3_q;
    sum_p4_d = sum_p3_q[0] + sum_p3_q[1];

    // Stage p5: shift/saturate; data and phase hold across invalid slots
    out_valid_d = tag_p4_q.vld;
    out_data_d  = tag_p4_q.vld ? sat_val : out_data_q;
    out_phase_d = tag_p4_q.vld ? tag_p4_q.phase : out_phase_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      abuf_q      <= '{default: '0};
      dbuf_q      <= '{default: '0};
      prod_p0_q   <= '{default: '0};
      sum_p1_q    <= '{default: '0};
      sum_p2_q    <= '{default: '0};
      sum_p3_q    <= '{default: '0};
      sum_p4_q    <= '0;
      tag_p0_q    <= '0;
      tag_p1_q    <= '0;
      tag_p2_q    <= '0;
      tag_p3_q    <= '0;
      tag_p4_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      abuf_q      <= abuf_d;
      dbuf_q      <= dbuf_d;
      prod_p0_q   <= prod_p0_d;
      sum_p1_q    <= sum_p1_d;
      sum_p2_q    <= sum_p2_d;
      sum_p3_q    <= sum_p3_d;
      sum_p4_q    <= sum_p4_d;
      tag_p0_q    <= tag_p0_d;
      tag_p1_q    <= tag_p1_d;
      tag_p2_q    <= tag_p2_d;
      tag_p3_q    <= tag_p3_d;
      tag_p4_q    <= tag_p4_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_phase_q <= out_phase_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_phase = out_phase_q;

endmodule
